// File: rtl/dsp_pkg.sv
// Shared DSP helpers: constant-function log2 and the delay-line constants
// and types used by the programmable delay line and its fill controller.
package dsp_pkg;

    localparam int DELAY_MIN = 1;

    // Which side of the legal range a requested delay fell on
    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_LOW  = 2'd1,
        CLAMP_HIGH = 2'd2
    } clamp_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Sample-stream bundle of the programmable delay line: stimulus side
// (enable, sample, qualifier, requested delay) and the delayed outputs.
interface prog_delay_line_if #(
    parameter int WIDTH = 16,
    parameter int DW    = 7
);
    logic             en_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic [DW-1:0]    delay_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             filled_o;
    logic [DW-1:0]    delay_o;

    modport master (
        output en_i, data_i, valid_i, delay_i,
        input  data_o, valid_o, filled_o, delay_o
    );

    modport slave (
        input  en_i, data_i, valid_i, delay_i,
        output data_o, valid_o, filled_o, delay_o
    );

endinterface

// File: rtl/delay_fill_ctrl.sv
// Delay clamp, effective-delay register and fill counter of the delay line.
// filled_o rises once delay_o samples were accepted since reset or the last change.
module delay_fill_ctrl
    import dsp_pkg::*;
#(
    parameter int MAX_DELAY = 64,
    parameter int DW        = clog2(MAX_DELAY + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [DW-1:0] delay_i,
    output logic [DW-1:0] delay_o,
    output logic          filled_o
);

    localparam logic [DW-1:0] DMIN = DW'(DELAY_MIN);
    localparam logic [DW-1:0] DMAX = DW'(MAX_DELAY);

    clamp_e        clamp_kind;
    logic [DW-1:0] delay_d, delay_q;
    logic [DW-1:0] cnt_d, cnt_q;
    logic          change;

    always_comb begin
        clamp_kind = CLAMP_NONE;
        if (delay_i == '0) begin
            clamp_kind = CLAMP_LOW;
        end else if (delay_i > DMAX) begin
            clamp_kind = CLAMP_HIGH;
        end

        delay_d = delay_i;
        unique case (clamp_kind)
            CLAMP_LOW:  delay_d = DMIN;
            CLAMP_HIGH: delay_d = DMAX;
            default:    delay_d = delay_i;
        endcase

        change = (delay_d != delay_q);

        // A change restarts the fill even if a sample is accepted on that edge
        cnt_d = cnt_q;
        if (change) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < delay_q)) begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay_q <= DMIN;
            cnt_q   <= '0;
        end else begin
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
        end
    end

    assign delay_o  = delay_q;
    assign filled_o = (cnt_q >= delay_q);

endmodule

// File: rtl/prog_delay_line.sv
// Programmable-depth delay line: a MAX_DELAY-deep sample/valid shift register
// advanced by en_i, tapped at the effective delay held by delay_fill_ctrl.
module prog_delay_line
    import dsp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_DELAY = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    prog_delay_line_if.slave   bus
);

    localparam int DW = clog2(MAX_DELAY + 1);
    localparam int AW = clog2(MAX_DELAY);

    logic [WIDTH-1:0]     stage_d   [MAX_DELAY];
    logic [WIDTH-1:0]     stage_q   [MAX_DELAY];
    logic [WIDTH-1:0]     shift_src [MAX_DELAY];
    logic [MAX_DELAY-1:0] stage_vld_d, stage_vld_q;
    logic [DW-1:0]        delay_q;
    logic                 filled;
    logic [AW-1:0]        tap_idx;

    // Each stage's shift source: the input for stage 0, its neighbour otherwise
    generate
        for (genvar gi = 0; gi < MAX_DELAY; gi++) begin : g_src
            if (gi == 0) begin : g_head
                assign shift_src[gi] = bus.data_i;
            end else begin : g_body
                assign shift_src[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < MAX_DELAY; k++) begin
            stage_d[k] = bus.en_i ? shift_src[k] : stage_q[k];
        end
        stage_vld_d = bus.en_i ? {stage_vld_q[MAX_DELAY-2:0], bus.valid_i} : stage_vld_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                stage_q[k] <= '0;
            end
            stage_vld_q <= '0;
        end else begin
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
        end
    end

    delay_fill_ctrl #(
        .MAX_DELAY (MAX_DELAY),
        .DW        (DW)
    ) u_fill (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (bus.en_i),
        .delay_i  (bus.delay_i),
        .delay_o  (delay_q),
        .filled_o (filled)
    );

    // delay_q is always within 1..MAX_DELAY, so the tap never leaves the array
    assign tap_idx      = AW'(delay_q - DW'(DELAY_MIN));
    assign bus.data_o   = stage_q[tap_idx];
    assign bus.valid_o  = stage_vld_q[tap_idx] & filled;
    assign bus.filled_o = filled;
    assign bus.delay_o  = delay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: stimulus pushes the expected output of
// every clock edge from a sample-history model; a monitor pops and compares.
module tb_prog_delay_line;

    localparam int WIDTH     = 16;
    localparam int MAX_DELAY = 64;
    localparam int DW        = 7;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
        logic             filled;
        logic [DW-1:0]    delay;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    prog_delay_line_if #(.WIDTH(WIDTH), .DW(DW)) bus ();

    prog_delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    exp_t             exp_q [$];
    logic [WIDTH-1:0] hist_d [$];
    logic             hist_v [$];
    int               m_delay;
    int               m_acc;
    int               tests = 0;
    int               fails = 0;
    bit               mon_armed = 1'b0;
    bit               stim_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Newest accepted sample at index 0; the history starts as MAX_DELAY zeros
    function automatic void model_reset();
        hist_d.delete();
        hist_v.delete();
        for (int i = 0; i < MAX_DELAY; i++) begin
            hist_d.push_back('0);
            hist_v.push_back(1'b0);
        end
        m_delay = 1;
        m_acc   = 0;
    endfunction

    function automatic int clamp_delay(input int d);
        if (d == 0) return 1;
        if (d > MAX_DELAY) return MAX_DELAY;
        return d;
    endfunction

    function automatic void model_step(input bit en, input logic [WIDTH-1:0] d,
                                       input bit v, input int dly);
        int   nd;
        bit   changed;
        exp_t e;
        nd      = clamp_delay(dly);
        changed = (nd != m_delay);
        if (changed) begin
            m_delay = nd;
            m_acc   = 0;
        end
        if (en) begin
            hist_d.push_front(d);
            hist_v.push_front(v);
            hist_d = hist_d[0:MAX_DELAY-1];
            hist_v = hist_v[0:MAX_DELAY-1];
            if (!changed) m_acc++;
        end
        e.delay  = DW'(m_delay);
        e.filled = (m_acc >= m_delay);
        e.data   = hist_d[m_delay-1];
        e.valid  = hist_v[m_delay-1] && e.filled;
        exp_q.push_back(e);
    endfunction

    function automatic void push_reset_state();
        exp_t e;
        e.data   = '0;
        e.valid  = 1'b0;
        e.filled = 1'b0;
        e.delay  = DW'(1);
        exp_q.push_back(e);
    endfunction

    task automatic cycle(input bit en, input logic [WIDTH-1:0] d, input bit v, input int dly);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        bus.en_i    = en;
        bus.data_i  = d;
        bus.valid_i = v;
        bus.delay_i = DW'(dly);
        mon_armed   = 1'b1;
        model_step(en, d, v, dly);
    endtask

    // Reset asserted between edges, held across exactly one rising edge
    task automatic async_reset();
        @(negedge clk_i);
        push_reset_state();
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_data_o", 32'(bus.data_o), 32'h0);
        check("rst_valid_o", 32'(bus.valid_o), 32'h0);
        check("rst_filled_o", 32'(bus.filled_o), 32'h0);
        check("rst_delay_o", 32'(bus.delay_o), 32'h1);
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[TB] t=%0t data_o=%h valid_o=%b filled_o=%b delay_o=%0d",
                         $time, bus.data_o, bus.valid_o, bus.filled_o, bus.delay_o);
                check("data_o", 32'(bus.data_o), 32'(e.data));
                check("valid_o", 32'(bus.valid_o), 32'(e.valid));
                check("filled_o", 32'(bus.filled_o), 32'(e.filled));
                check("delay_o", 32'(bus.delay_o), 32'(e.delay));
            end else if (mon_armed && !stim_done) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'h1);
            end
        end
    end

    initial begin : stimulus
        int cur_dly;
        bus.en_i    = 1'b0;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.delay_i = '0;
        model_reset();
        #1;
        rst_ni = 1'b0;
        #2;
        check("init_data_o", 32'(bus.data_o), 32'h0);
        check("init_valid_o", 32'(bus.valid_o), 32'h0);
        check("init_filled_o", 32'(bus.filled_o), 32'h0);
        check("init_delay_o", 32'(bus.delay_o), 32'h1);

        for (int i = 1; i <= 6; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1);
        for (int i = 1; i <= 20; i++) cycle(1'b1, WIDTH'(i), 1'b1, 5);
        for (int i = 0; i < 24; i++) cycle((i % 2) == 0, WIDTH'(16'h100 + i), 1'b1, 5);
        for (int i = 0; i < 12; i++) cycle(1'b1, WIDTH'(16'h200 + i), 1'b1, 4);
        for (int i = 0; i < 16; i++) cycle(1'b1, WIDTH'(16'h300 + i), 1'b1, 8);
        for (int i = 0; i < 6; i++) cycle(1'b1, WIDTH'(16'h400 + i), 1'b1, 0);
        for (int i = 0; i < 80; i++) cycle(1'b1, WIDTH'(16'h500 + i), 1'b1, MAX_DELAY + 5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'hdead, 1'b1, MAX_DELAY + 5);
        for (int i = 0; i < 8; i++) cycle(1'b1, WIDTH'(16'h600 + i), 1'b1, 3);
        async_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, WIDTH'(16'h700 + i), 1'b1, 3);

        cur_dly = 3;
        for (int n = 0; n < 2000; n++) begin
            if (($urandom % 40) == 0) cur_dly = int'($urandom_range(0, 80));
            if (($urandom % 500) == 0) begin
                async_reset();
            end else begin
                cycle(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 5) != 0, cur_dly);
            end
        end

        stim_done = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Parametrised, programmable-depth delay line. Successor to the single-stage data register.
- Delays a WIDTH-bit sample stream by a run-time-selectable number of clock-enabled cycles, from 1 to MAX_DELAY.
- Tracks per-sample valid and pipeline fill state. Used to time-align signal paths in the Red Pitaya processing chain, e.g. feedback and noise branches.

Parameters:
- WIDTH, 16: sample width in bits.
- MAX_DELAY, 64: number of storage stages, i.e. maximum programmable delay. Legal range is 2..1024.
- DW, $clog2(MAX_DELAY+1): localparam, width of the delay control and of the fill counter.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- en_i  in  1  clock enable. The line advances only when en_i=1.
- data_i  in  WIDTH  input sample.
- valid_i  in  1  input sample qualifier; travels with data.
- delay_i  in  DW  requested delay D, in enable cycles.
- data_o  out  WIDTH  delayed sample.
- valid_o  out  1  delayed qualifier, gated by filled_o.
- filled_o  out  1  high once D samples have been accepted since the last reset or delay change.
- delay_o  out  DW  delay value currently in effect (clamped).

Behaviour:
- Reset (rst_ni=0, asynchronous): all stages and stage-valid bits are 0, the fill counter is 0, delay_q is 1. Outputs: data_o=0, valid_o=0, filled_o=0, delay_o=1.
- Storage: stage[0..MAX_DELAY-1].
  - When en_i=1: stage[0]<=data_i, stage[k]<=stage[k-1]; stage-valid bits shift identically.
  - When en_i=0: all stages hold.
- Delay clamp: Dc = 1 if delay_i==0; MAX_DELAY if delay_i>MAX_DELAY; otherwise delay_i.
- delay_q is a register updated to Dc every clock, independent of en_i. delay_o=delay_q.
- Output tap is combinational from registers: data_o=stage[delay_q-1]. A sample presented with en_i=1 appears on data_o after exactly delay_q enabled edges. With delay_q=1 the block is identical to a plain registered stage.
- Fill counter cnt:
  - If Dc != delay_q (change detected): cnt<=0 on that edge. A change takes priority over a simultaneous en_i.
  - Else if en_i=1 and cnt<delay_q: cnt<=cnt+1.
  - cnt saturates at delay_q and never wraps.
- filled_o = (cnt >= delay_q).
- valid_o = stage_valid[delay_q-1] & filled_o. This suppresses stale samples exposed when the delay is increased.
- After a decrease the data is genuine, but the counter still refills. The conservative rule applies uniformly.
- data_o is not gated; it shows stage contents regardless of valid_o.
- en_i=0 for any number of cycles: outputs constant, cnt constant.
- Delay change and en_i=1 on the same edge: the data still shifts and cnt becomes 0. The sample accepted on that edge is not counted toward fill.
- Reset mid-stream: everything clears at once. The first valid_o appears delay_q enabled cycles after release (delay_q is 1 on the first cycle after reset, then follows delay_i).
- No combinational path from data_i or valid_i to any output.

Decomposition:
- Shared package dsp_pkg:
  - function clog2 helper, if not already present.
  - constant DELAY_MIN=1.
- One natural sub-module: delay_fill_ctrl. It holds the clamp, delay_q, change detection, cnt and filled_o.
- The stage array and tap mux stay in the top module.

Test Plan:
- Reset then delay_i=1, en_i=1, ramp data_i 1,2,3 with valid_i=1. Required: data_o follows with 1-cycle latency, and valid_o=1 from the first enabled cycle after cnt reaches 1.
- delay_i=5, ramp 0x0001.. with en_i=1. Required: data_o=0x0001 on the 5th edge after first acceptance, filled_o rises on the same edge, valid_o=1 thereafter.
- delay_i=5, en_i toggling 1,0,1,0. Required: the output advances only on enabled edges, so the delay is 5 enabled edges (10 clocks), and cnt holds while en_i=0.
- Steady state at D=4, then switch delay_i to 8. Required: filled_o and valid_o drop the next cycle, data_o shows the stage[7] content, and valid_o returns after 8 enabled edges.
- delay_i=0, then delay_i=MAX_DELAY+5 (e.g. 69 with MAX_DELAY=64). Required: delay_o=1, then 64, with matching latencies.
- Assert rst_ni low asynchronously mid-stream at D=3. Required: data_o=0, valid_o=0, filled_o=0 immediately without a clock edge, and normal refill after release.
